data_memory_bank: RTL and testbench

- Parametrised successor to the processor's single-port 8-bit data memory.
- Adds a valid/ready request port, a registered 1-cycle read response and a hardware clear sweep after reset or on demand.
- Supports DEPTH not a power of two, with an out-of-range address error.
- Sits between the SOAT load/store unit and on-chip RAM; one request per cycle at full throughput.

---
 rtl/data_memory_bank.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory_bank.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bank.sv
// ---------------------------------------------------------------------------
// data_memory_bank
//   Parametrised single-port data memory for the load/store unit. Accepts one
//   valid/ready request per cycle, returns reads one cycle later on a
//   registered response port, and zeroes the whole array with a hardware
//   sweep after reset or on a clear_req pulse. DEPTH need not be a power of
//   two; addresses >= DEPTH are dropped (writes) or flagged (reads).
//
//   Optional build macro: MEM_PARITY_EN
//     Adds an even-parity bit per word, an err_inject hook on writes and a
//     parity check on reads (rsp_perr). Without it rsp_perr is tied 0 and
//     err_inject is ignored; the port list is identical in both builds.
//
//   Ports
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     req_valid    request present
//     req_ready    request accepted this cycle when high (0 during sweep)
//     req_write    1 = write, 0 = read
//     req_addr     word address
//     req_wdata    write data
//     clear_req    single-cycle pulse restarting the clear sweep
//     err_inject   store inverted parity on this write (parity build only)
//     rsp_valid    one-cycle read response pulse
//     rsp_rdata    read data, held until the next response
//     rsp_err      read address was out of range, held
//     rsp_perr     stored parity mismatch on read, held
//     init_done    sweep finished, memory usable
// ---------------------------------------------------------------------------
module data_memory_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clear_req,
  input  logic              err_inject,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_perr,
  output logic              init_done
);

  // Index width covers exactly DEPTH words; upper address bits only feed the
  // range check.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                req_ready_q;
  logic                init_done_q;

  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_perr_q;

  logic [MEM_W-1:0]    mem [DEPTH];

  logic                req_acc;
  logic                wr_acc;
  logic                rd_acc;
  logic                addr_in_range;

  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [MEM_W-1:0]    mem_wword;
  logic [MEM_W-1:0]    mem_rword;
  logic                par_bad;

  // Request handshake; req_ready_q is only ever high in READY.
  assign req_acc       = req_valid && req_ready_q;
  assign wr_acc        = req_acc && req_write;
  assign rd_acc        = req_acc && !req_write;
  assign addr_in_range = ({1'b0, req_addr} < DEPTH_X);

  // Sweep / ready state machine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q     <= ST_READY;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_READY: begin
          // A request accepted in the same cycle still completes normally.
          if (clear_req) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_CLEAR;
          cnt_q       <= '0;
          req_ready_q <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: sweep zeroes word[cnt], otherwise in-range writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wword = '0;
    if (state_q == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_widx = cnt_q[IDX_W-1:0];
    end else if (wr_acc && addr_in_range) begin
      mem_we   = 1'b1;
      mem_widx = req_addr[IDX_W-1:0];
`ifdef MEM_PARITY_EN
      mem_wword = {(^req_wdata) ^ err_inject, req_wdata};
`else
      mem_wword = req_wdata;
`endif
    end
  end

`ifndef MEM_PARITY_EN
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
`endif

  // Storage array; contents are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wword;
    end
  end

  // Asynchronous array read, only consumed for in-range addresses.
  assign mem_rword = mem[req_addr[IDX_W-1:0]];

`ifdef MEM_PARITY_EN
  assign par_bad = (mem_rword[MEM_W-1] != (^mem_rword[DATA_W-1:0]));
`else
  assign par_bad = 1'b0;
`endif

  // Registered read response; data and flags hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_perr_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rd_acc;
      if (rd_acc) begin
        if (addr_in_range) begin
          rsp_rdata_q <= mem_rword[DATA_W-1:0];
          rsp_err_q   <= 1'b0;
          rsp_perr_q  <= par_bad;
        end else begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
          rsp_perr_q  <= 1'b0;
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// ---------------------------------------------------------------------------
// tb_data_memory_bank
//   Directed scenarios plus randomized back-to-back traffic for
//   data_memory_bank (DEPTH=200), checked against an array model of the
//   memory contents and a one-deep expected-response register.
// ---------------------------------------------------------------------------
module tb_data_memory_bank;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 200;

`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              clear_req = 1'b0;
  logic              err_inject = 1'b0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_perr;
  logic              init_done;

  int checks = 0;
  int passed = 0;

  // Behavioural memory model: data plus "stored parity is wrong" flag.
  logic [7:0] mem_m [256];
  logic       bad_m [256];

  always #5 clk = ~clk;

  data_memory_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .clear_req (clear_req),
    .err_inject(err_inject),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_perr  (rsp_perr),
    .init_done (init_done)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    err_inject = 1'b0;
    clear_req  = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 8'h00;
      bad_m[i] = 1'b0;
    end
  endtask

  // Counts edges until req_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < int'(DEPTH) + 50) begin
      cycle();
      n++;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic inj);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = a;
    req_wdata  = d;
    err_inject = inj;
    if (a < DEPTH) begin
      mem_m[a] = d;
      bad_m[a] = PAR && inj;
    end
    cycle();
    idle();
  endtask

  task automatic rd(input logic [7:0] a);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = a;
    err_inject = 1'b0;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({req_ready, init_done, rsp_valid, rsp_err, rsp_perr, rsp_rdata} !== 13'h0)
      $display("FAIL reset_outputs: got %b required 0",
               {req_ready, init_done, rsp_valid, rsp_err, rsp_perr, rsp_rdata});
    else passed++;
    rst_n = 1'b1;
    wait_ready(n);
    model_clear();
    checks++;
    if (n !== int'(DEPTH)) $display("FAIL reset_sweep_len: got %0d required %0d", n, DEPTH);
    else passed++;
    checks++;
    if ({req_ready, init_done} !== 2'b11)
      $display("FAIL reset_ready: got %b required 11", {req_ready, init_done});
    else passed++;
    rd(8'h00);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL read_00_after_sweep: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
    rd(8'hC7);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL read_c7_after_sweep: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_write_read();
    wr(8'h10, 8'h5A, 1'b0);
    rd(8'h10);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h5A})
      $display("FAIL write_then_read: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h5A});
    else passed++;
    cycle();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 8'h5A})
      $display("FAIL rsp_pulse_hold: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 8'h5A});
    else passed++;
  endtask

  task automatic test_out_of_range();
    wr(8'hC8, 8'hFF, 1'b0);
    rd(8'hC8);
    checks++;
    if ({rsp_valid, rsp_err, rsp_perr, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 8'h00})
      $display("FAIL oor_read: got %h required %h", {rsp_valid, rsp_err, rsp_perr, rsp_rdata}, {1'b1, 1'b1, 1'b0, 8'h00});
    else passed++;
    rd(8'hC7);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL last_word_untouched: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_clear_with_read();
    int n;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    clear_req = 1'b1;
    cycle();
    idle();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h5A})
      $display("FAIL clear_same_cycle_read: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h5A});
    else passed++;
    checks++;
    if ({req_ready, init_done} !== 2'b00)
      $display("FAIL clear_drops_ready: got %b required 00", {req_ready, init_done});
    else passed++;
    // Mid-sweep: a second clear_req and a write to an already-swept word must be ignored.
    for (int i = 0; i < 100; i++) begin
      clear_req = (i == 50);
      if (i >= 60) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h05;
        req_wdata = 8'hEE;
      end
      cycle();
    end
    idle();
    wait_ready(n);
    model_clear();
    checks++;
    if (n + 100 !== int'(DEPTH)) $display("FAIL clear_sweep_len: got %0d required %0d", n + 100, DEPTH);
    else passed++;
    checks++;
    if ({req_ready, init_done} !== 2'b11)
      $display("FAIL clear_ready: got %b required 11", {req_ready, init_done});
    else passed++;
    rd(8'h10);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL read_10_after_clear: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
    rd(8'h05);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL write_during_clear: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    wr(8'h20, 8'hA5, 1'b0);
    rd(8'h20);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (50) cycle();
    checks++;
    if ({req_ready, rsp_rdata} !== {1'b0, 8'hA5})
      $display("FAIL hold_during_sweep: got %h required %h", {req_ready, rsp_rdata}, {1'b0, 8'hA5});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, init_done, rsp_valid, rsp_err, rsp_perr, rsp_rdata} !== 13'h0)
      $display("FAIL async_reset: got %b required 0",
               {req_ready, init_done, rsp_valid, rsp_err, rsp_perr, rsp_rdata});
    else passed++;
    cycle();
    rst_n = 1'b1;
    wait_ready(n);
    model_clear();
    checks++;
    if (n !== int'(DEPTH)) $display("FAIL resweep_len: got %0d required %0d", n, DEPTH);
    else passed++;
    rd(8'h20);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL read_after_resweep: got %h required %h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_parity();
    wr(8'h40, 8'h33, 1'b1);
    rd(8'h40);
    checks++;
    if ({rsp_valid, rsp_perr, rsp_rdata} !== {1'b1, PAR, 8'h33})
      $display("FAIL parity_inject: got %h required %h", {rsp_valid, rsp_perr, rsp_rdata}, {1'b1, PAR, 8'h33});
    else passed++;
    wr(8'h40, 8'h33, 1'b0);
    rd(8'h40);
    checks++;
    if ({rsp_valid, rsp_perr, rsp_rdata} !== {1'b1, 1'b0, 8'h33})
      $display("FAIL parity_clean: got %h required %h", {rsp_valid, rsp_perr, rsp_rdata}, {1'b1, 1'b0, 8'h33});
    else passed++;
  endtask

  // Random requests every cycle; each response is predicted at issue time.
  task automatic test_back_to_back_random();
    logic       v, w, inj, ev, ee, ep, have_last;
    logic [7:0] a, d, ed, ld;
    logic       le, lp;
    have_last = 1'b0;
    ld = 8'h00;
    le = 1'b0;
    lp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 31));
      d   = 8'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      req_valid  = v;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      err_inject = inj;
      ev = v && !w;
      ed = 8'h00;
      ee = 1'b0;
      ep = 1'b0;
      if (ev) begin
        if (a < DEPTH) begin
          ed = mem_m[a];
          ep = bad_m[a];
        end else begin
          ee = 1'b1;
        end
      end
      if (v && w && a < DEPTH) begin
        mem_m[a] = d;
        bad_m[a] = PAR && inj;
      end
      cycle();
      checks++;
      if ({rsp_valid, req_ready} !== {ev, 1'b1})
        $display("FAIL b2b_valid[%0d]: got %b required %b", i, {rsp_valid, req_ready}, {ev, 1'b1});
      else passed++;
      if (ev) begin
        have_last = 1'b1;
        ld = ed;
        le = ee;
        lp = ep;
      end
      if (have_last) begin
        checks++;
        if ({rsp_rdata, rsp_err, rsp_perr} !== {ld, le, lp})
          $display("FAIL b2b_data[%0d]: got %h required %h", i, {rsp_rdata, rsp_err, rsp_perr}, {ld, le, lp});
        else passed++;
      end
    end
    idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_clear_with_read();
    test_reset_mid_sweep();
    test_parity();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
